// File: rtl/ps2_letter_queue.sv
// PS/2 set-2 letter decoder feeding a keystroke queue, with typematic filtering.
// Build option: define KEY_FIFO_EN for a FIFO_DEPTH-entry circular FIFO; otherwise one holding register.
module ps2_letter_queue #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  scan_code,
  input  logic        scan_ready,
  output logic        read,
  input  logic        clear,
  input  logic        take,
  output logic        valid,
  output logic [4:0]  letter_idx,
  output logic [25:0] letter,
  output logic [4:0]  count,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

  localparam logic [4:0] NO_KEY = 5'h1F;

  // {hit, idx} for the 26 letter make codes
  function automatic logic [5:0] decode(input logic [7:0] c);
    case (c)
      8'h1C: decode = {1'b1, 5'd0};   8'h32: decode = {1'b1, 5'd1};
      8'h21: decode = {1'b1, 5'd2};   8'h23: decode = {1'b1, 5'd3};
      8'h24: decode = {1'b1, 5'd4};   8'h2B: decode = {1'b1, 5'd5};
      8'h34: decode = {1'b1, 5'd6};   8'h33: decode = {1'b1, 5'd7};
      8'h43: decode = {1'b1, 5'd8};   8'h3B: decode = {1'b1, 5'd9};
      8'h42: decode = {1'b1, 5'd10};  8'h4B: decode = {1'b1, 5'd11};
      8'h3A: decode = {1'b1, 5'd12};  8'h31: decode = {1'b1, 5'd13};
      8'h44: decode = {1'b1, 5'd14};  8'h4D: decode = {1'b1, 5'd15};
      8'h15: decode = {1'b1, 5'd16};  8'h2D: decode = {1'b1, 5'd17};
      8'h1B: decode = {1'b1, 5'd18};  8'h2C: decode = {1'b1, 5'd19};
      8'h3C: decode = {1'b1, 5'd20};  8'h2A: decode = {1'b1, 5'd21};
      8'h1D: decode = {1'b1, 5'd22};  8'h22: decode = {1'b1, 5'd23};
      8'h35: decode = {1'b1, 5'd24};  8'h1A: decode = {1'b1, 5'd25};
      default: decode = 6'd0;
    endcase
  endfunction

  logic       rdy_q, arm_q, read_q;
  state_t     state_q;
  logic [4:0] held_q;
  logic [4:0] count_q;
  logic       ovf_q;

  logic       accept, hit, push, pop, full, wr;
  logic [4:0] code_idx, head_idx;

  // arm_q blocks a level left high across reset from being taken as a new byte
  assign accept = scan_ready & ~rdy_q & arm_q;
  assign {hit, code_idx} = decode(scan_code);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdy_q  <= 1'b0;
      arm_q  <= 1'b0;
      read_q <= 1'b0;
    end else begin
      rdy_q  <= scan_ready;
      read_q <= accept;
      if (!scan_ready) arm_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      held_q  <= NO_KEY;
    end else if (clear) begin
      state_q <= IDLE;
      held_q  <= NO_KEY;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (scan_code == 8'hF0)      state_q <= BREAK;
          else if (scan_code == 8'hE0) state_q <= EXT;
          else if (hit)                held_q  <= code_idx;
        end
        BREAK: begin
          if (hit && code_idx == held_q) held_q <= NO_KEY;
          state_q <= IDLE;
        end
        EXT:       state_q <= (scan_code == 8'hF0) ? EXT_BREAK : IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign push = accept & ~clear & (state_q == IDLE) & hit & (code_idx != held_q);

`ifdef KEY_FIFO_EN
  localparam int QDEPTH = FIFO_DEPTH;
  localparam int PW     = $clog2(FIFO_DEPTH);

  logic [4:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;

  // power-of-two depth: pointers wrap naturally
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clear) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr)  wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr) mem_q[wptr_q] <= code_idx;
  end

  assign head_idx = mem_q[rptr_q];
`else
  localparam int QDEPTH = 1;

  logic [4:0] head_q;

  always_ff @(posedge clock) begin
    if (wr) head_q <= code_idx;
  end

  assign head_idx = head_q;
`endif

  assign full = (count_q == 5'(QDEPTH));
  assign pop  = take & (count_q != 5'd0);
  // when full, a same-edge pop frees the slot being written
  assign wr   = push & (~full | pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= 5'd0;
      ovf_q   <= 1'b0;
    end else if (clear) begin
      count_q <= 5'd0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr && !pop)      count_q <= count_q + 5'd1;
      else if (!wr && pop) count_q <= count_q - 5'd1;
      if (push && !wr)     ovf_q   <= 1'b1;
    end
  end

  assign read       = read_q;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign valid      = (count_q != 5'd0);
  assign letter_idx = valid ? head_idx : 5'd0;
  assign letter     = valid ? (26'd1 << letter_idx) : 26'd0;

endmodule

// File: tb/tb_ps2_letter_queue.sv
// Directed bench for ps2_letter_queue; expected values hand-derived from the make-code table.
module tb_ps2_letter_queue;

`ifdef KEY_FIFO_EN
  localparam int QD = 4;
`else
  localparam int QD = 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  scan_code = 8'h00;
  logic        scan_ready = 1'b0;
  logic        read;
  logic        clear = 1'b0;
  logic        take = 1'b0;
  logic        valid;
  logic [4:0]  letter_idx;
  logic [25:0] letter;
  logic [4:0]  count;
  logic        overflow;

  int vec_cnt = 0;
  int err_cnt = 0;
  int rd_cnt  = 0;

  logic [7:0] mk [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                          8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                          8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  ps2_letter_queue #(.FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .scan_code(scan_code), .scan_ready(scan_ready),
    .read(read), .clear(clear), .take(take), .valid(valid), .letter_idx(letter_idx),
    .letter(letter), .count(count), .overflow(overflow)
  );

  always #10 clock = ~clock;

  always @(posedge clock) if (read) rd_cnt++;

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock); scan_code = b; scan_ready = 1'b1;
    @(negedge clock); scan_ready = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_pop;
    @(negedge clock); take = 1'b1;
    @(negedge clock); take = 1'b0;
  endtask

  task automatic do_clear;
    @(negedge clock); clear = 1'b1;
    @(negedge clock); clear = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    vec_cnt++; if (read !== 1'b0)     begin err_cnt++; $display("FAIL rst_read got %b want 0", read); end
    vec_cnt++; if (valid !== 1'b0)    begin err_cnt++; $display("FAIL rst_valid got %b want 0", valid); end
    vec_cnt++; if (letter_idx !== 5'd0) begin err_cnt++; $display("FAIL rst_idx got %0d want 0", letter_idx); end
    vec_cnt++; if (letter !== 26'd0)  begin err_cnt++; $display("FAIL rst_letter got %h want 0", letter); end
    vec_cnt++; if (count !== 5'd0)    begin err_cnt++; $display("FAIL rst_count got %0d want 0", count); end
    vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL rst_ovf got %b want 0", overflow); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_ack_and_release;
    rd_cnt = 0;
    @(negedge clock); scan_code = 8'h1C; scan_ready = 1'b1;
    @(negedge clock);
    vec_cnt++; if (read !== 1'b1) begin err_cnt++; $display("FAIL ack_pulse got %b want 1", read); end
    @(negedge clock);
    vec_cnt++; if (read !== 1'b0) begin err_cnt++; $display("FAIL ack_one_cycle got %b want 0", read); end
    scan_ready = 1'b0;
    @(negedge clock);
    send_byte(8'hF0);
    send_byte(8'h1C);
    vec_cnt++; if (rd_cnt !== 3)       begin err_cnt++; $display("FAIL ack_count got %0d want 3", rd_cnt); end
    vec_cnt++; if (valid !== 1'b1)     begin err_cnt++; $display("FAIL a_valid got %b want 1", valid); end
    vec_cnt++; if (count !== 5'd1)     begin err_cnt++; $display("FAIL a_count got %0d want 1", count); end
    vec_cnt++; if (letter_idx !== 5'd0) begin err_cnt++; $display("FAIL a_idx got %0d want 0", letter_idx); end
    vec_cnt++; if (letter !== 26'h0000001) begin err_cnt++; $display("FAIL a_letter got %h want 0000001", letter); end
    do_pop();
    vec_cnt++; if (valid !== 1'b0 || letter !== 26'd0) begin err_cnt++; $display("FAIL a_popped valid %b letter %h want 0/0", valid, letter); end
  endtask

  task automatic test_typematic;
    logic [7:0] seq [6] = '{8'h2D, 8'h2D, 8'h2D, 8'hF0, 8'h2D, 8'h2D};
    do_clear();
    foreach (seq[i]) send_byte(seq[i]);
    vec_cnt++; if (count !== 5'(QD < 2 ? QD : 2)) begin err_cnt++; $display("FAIL rep_count got %0d want %0d", count, (QD < 2 ? QD : 2)); end
    vec_cnt++; if (letter_idx !== 5'd17) begin err_cnt++; $display("FAIL rep_idx0 got %0d want 17", letter_idx); end
    vec_cnt++; if (letter !== 26'h0020000) begin err_cnt++; $display("FAIL rep_letter got %h want 0020000", letter); end
    do_pop();
    if (QD > 1) begin
      vec_cnt++; if (letter_idx !== 5'd17 || count !== 5'd1) begin err_cnt++; $display("FAIL rep_idx1 got %0d cnt %0d want 17/1", letter_idx, count); end
      do_pop();
    end
    vec_cnt++; if (valid !== 1'b0) begin err_cnt++; $display("FAIL rep_empty got %b want 0", valid); end
    @(negedge clock); take = 1'b1;
    @(negedge clock); take = 1'b0;
    vec_cnt++; if (count !== 5'd0) begin err_cnt++; $display("FAIL empty_take got %0d want 0", count); end
  endtask

  task automatic test_extended;
    do_clear();
    send_byte(8'hE0); send_byte(8'h1C);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h1C);
    vec_cnt++; if (count !== 5'd0 || valid !== 1'b0) begin err_cnt++; $display("FAIL ext_drop cnt %0d valid %b want 0/0", count, valid); end
    send_byte(8'h4B);
    vec_cnt++; if (letter_idx !== 5'd11 || count !== 5'd1) begin err_cnt++; $display("FAIL ext_idle got %0d cnt %0d want 11/1", letter_idx, count); end
    do_pop();
  endtask

  task automatic test_overflow;
    do_clear();
    for (int i = 0; i < 5; i++) send_byte(mk[i]);
    vec_cnt++; if (count !== 5'(QD)) begin err_cnt++; $display("FAIL ovf_count got %0d want %0d", count, QD); end
    vec_cnt++; if (overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_flag got %b want 1", overflow); end
    for (int i = 0; i < QD; i++) begin
      vec_cnt++; if (letter_idx !== 5'(i)) begin err_cnt++; $display("FAIL ovf_order%0d got %0d want %0d", i, letter_idx, i); end
      do_pop();
    end
    vec_cnt++; if (valid !== 1'b0 || overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_after valid %b ovf %b want 0/1", valid, overflow); end
  endtask

  task automatic test_clear;
    send_byte(8'h21);
    vec_cnt++; if (count !== 5'd1) begin err_cnt++; $display("FAIL clr_pre got %0d want 1", count); end
    @(negedge clock); clear = 1'b1; scan_code = 8'h23; scan_ready = 1'b1;
    @(negedge clock); clear = 1'b0; scan_ready = 1'b0;
    vec_cnt++; if (count !== 5'd0 || overflow !== 1'b0) begin err_cnt++; $display("FAIL clr_state cnt %0d ovf %b want 0/0", count, overflow); end
    vec_cnt++; if (read !== 1'b1) begin err_cnt++; $display("FAIL clr_read got %b want 1", read); end
    @(negedge clock);
    send_byte(8'h21);
    vec_cnt++; if (count !== 5'd1 || letter_idx !== 5'd2) begin err_cnt++; $display("FAIL clr_held cnt %0d idx %0d want 1/2", count, letter_idx); end
  endtask

  task automatic test_back_to_back;
    do_clear();
    for (int i = 0; i < QD; i++) send_byte(mk[i]);
    @(negedge clock); scan_code = 8'h1A; scan_ready = 1'b1; take = 1'b1;
    @(negedge clock); scan_ready = 1'b0; take = 1'b0;
    vec_cnt++; if (count !== 5'(QD) || overflow !== 1'b0) begin err_cnt++; $display("FAIL b2b_count cnt %0d ovf %b want %0d/0", count, overflow, QD); end
    for (int i = 1; i < QD; i++) begin
      vec_cnt++; if (letter_idx !== 5'(i)) begin err_cnt++; $display("FAIL b2b_order%0d got %0d want %0d", i, letter_idx, i); end
      do_pop();
    end
    vec_cnt++; if (letter_idx !== 5'd25 || count !== 5'd1) begin err_cnt++; $display("FAIL b2b_last got %0d cnt %0d want 25/1", letter_idx, count); end
    do_pop();
  endtask

  task automatic test_async_reset;
    do_clear();
    send_byte(mk[0]); send_byte(mk[1]);
    vec_cnt++; if (count !== 5'(QD < 2 ? QD : 2)) begin err_cnt++; $display("FAIL ar_pre got %0d want %0d", count, (QD < 2 ? QD : 2)); end
    @(negedge clock); #5 reset = 1'b0; #1;
    vec_cnt++; if (valid !== 1'b0 || count !== 5'd0) begin err_cnt++; $display("FAIL ar_async valid %b cnt %0d want 0/0", valid, count); end
    scan_code = 8'h15; scan_ready = 1'b1;
    @(negedge clock); reset = 1'b1;
    repeat (2) @(negedge clock);
    vec_cnt++; if (read !== 1'b0 || count !== 5'd0) begin err_cnt++; $display("FAIL ar_level read %b cnt %0d want 0/0", read, count); end
    scan_ready = 1'b0;
    @(negedge clock);
    send_byte(8'h15);
    vec_cnt++; if (valid !== 1'b1 || letter_idx !== 5'd16) begin err_cnt++; $display("FAIL ar_q valid %b idx %0d want 1/16", valid, letter_idx); end
    vec_cnt++; if (letter !== 26'h0010000) begin err_cnt++; $display("FAIL ar_q_letter got %h want 0010000", letter); end
  endtask

  initial begin
    test_reset();
    test_ack_and_release();
    test_typematic();
    test_extended();
    test_overflow();
    test_clear();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
